// File: rtl/ber_pkg.sv
// Shared types and helpers for the multi-channel PRBS BER checker.
// Lane FSM encoding, PRBS feedback and saturating counter increment.
package ber_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_QUAL   = 2'd1,
    ST_LOCKED = 2'd2
  } lane_st_e;

  localparam int unsigned MAX_W = 64;

  function automatic logic prbs_fb(input logic [MAX_W-1:0] st, input logic [MAX_W-1:0] taps);
    return ^(st & taps);
  endfunction

  // Increment that sticks at the all-ones value of a w-bit counter.
  function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] v, input int unsigned w);
    logic [MAX_W-1:0] lim;
    lim = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    return (v >= lim) ? v : v + MAX_W'(1);
  endfunction

endpackage

// File: rtl/ber_chk_lane.sv
// One BER lane: self-synchronising PRBS LFSR, lock qualification,
// loss-of-lock window monitor and saturating error/total/relock counters.
module ber_chk_lane
  import ber_pkg::*;
#(
  parameter int                  PRBS_LEN     = 9,
  parameter logic [PRBS_LEN-1:0] PRBS_TAPS    = 9'h110,
  parameter int                  SYNC_WIN     = 511,
  parameter int                  LOCK_ERR_MAX = 0,
  parameter int                  LOSS_WIN     = 1024,
  parameter int                  LOSS_ERR_MAX = 64,
  parameter int                  CNT_W        = 64
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_stb,
  input  logic             i_clear,
  input  logic             i_rx,
  output logic [CNT_W-1:0] o_err,
  output logic [CNT_W-1:0] o_tot,
  output logic [7:0]       o_relock,
  output logic             o_locked,
  output logic             o_led
);

  localparam int SEQ_MAX = (SYNC_WIN > PRBS_LEN) ? SYNC_WIN : PRBS_LEN;
  localparam int LC_W    = $clog2(SEQ_MAX + 1);
  localparam int QE_W    = $clog2(SYNC_WIN + 1);
  localparam int WC_W    = $clog2(LOSS_WIN + 1);

  lane_st_e            st_q, st_d;
  logic [LC_W-1:0]     cnt_q, cnt_d;
  logic [PRBS_LEN-1:0] lfsr_q, lfsr_d;
  logic [QE_W-1:0]     qerr_q, qerr_d;
  logic [WC_W-1:0]     wcnt_q, wcnt_d, werr_q, werr_d;
  logic [CNT_W-1:0]    err_q, err_d, tot_q, tot_d;
  logic [7:0]          relock_q, relock_d;
  logic                led_q, led_d;

  logic                pred, e;
  logic [PRBS_LEN-1:0] lfsr_ld, lfsr_fr;
  logic [QE_W-1:0]     qerr_sum;
  logic [WC_W-1:0]     werr_sum;

  assign pred     = prbs_fb(MAX_W'(lfsr_q), MAX_W'(PRBS_TAPS));
  assign e        = i_rx ^ pred;
  assign lfsr_ld  = {lfsr_q[PRBS_LEN-2:0], i_rx};
  assign lfsr_fr  = {lfsr_q[PRBS_LEN-2:0], pred};
  // Sums include the current bit so window/qualification decisions see it.
  assign qerr_sum = qerr_q + QE_W'(e);
  assign werr_sum = werr_q + WC_W'(e);

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    qerr_d   = qerr_q;
    wcnt_d   = wcnt_q;
    werr_d   = werr_q;
    err_d    = err_q;
    tot_d    = tot_q;
    relock_d = relock_q;
    led_d    = led_q;
    if (i_stb) begin
      unique case (st_q)
        ST_LOAD: begin
          lfsr_d = lfsr_ld;
          if (cnt_q == LC_W'(PRBS_LEN - 1)) begin
            cnt_d = '0;
            // An all-zero seed would free-run as zeros and falsely lock.
            if (lfsr_ld != '0) begin
              st_d   = ST_QUAL;
              qerr_d = '0;
            end
          end else begin
            cnt_d = cnt_q + LC_W'(1);
          end
        end
        ST_QUAL: begin
          lfsr_d = lfsr_fr;
          qerr_d = qerr_sum;
          if (cnt_q == LC_W'(SYNC_WIN - 1)) begin
            cnt_d = '0;
            if (32'(qerr_sum) <= 32'(LOCK_ERR_MAX)) begin
              st_d   = ST_LOCKED;
              wcnt_d = '0;
              werr_d = '0;
            end else begin
              st_d = ST_LOAD;
            end
          end else begin
            cnt_d = cnt_q + LC_W'(1);
          end
        end
        ST_LOCKED: begin
          lfsr_d = lfsr_fr;
          tot_d  = CNT_W'(sat_inc(MAX_W'(tot_q), CNT_W));
          if (e) err_d = CNT_W'(sat_inc(MAX_W'(err_q), CNT_W));
          wcnt_d = wcnt_q + WC_W'(1);
          werr_d = werr_sum;
          if (wcnt_q == WC_W'(LOSS_WIN - 1)) begin
            wcnt_d = '0;
            werr_d = '0;
            led_d  = (werr_sum == '0);
            if (32'(werr_sum) > 32'(LOSS_ERR_MAX)) begin
              st_d     = ST_LOAD;
              cnt_d    = '0;
              led_d    = 1'b0;
              relock_d = 8'(sat_inc(MAX_W'(relock_q), 8));
            end
          end
        end
        default: st_d = ST_LOAD;
      endcase
    end
    if (i_clear) begin
      err_d    = '0;
      tot_d    = '0;
      relock_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      st_q     <= ST_LOAD;
      cnt_q    <= '0;
      lfsr_q   <= '0;
      qerr_q   <= '0;
      wcnt_q   <= '0;
      werr_q   <= '0;
      err_q    <= '0;
      tot_q    <= '0;
      relock_q <= '0;
      led_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      qerr_q   <= qerr_d;
      wcnt_q   <= wcnt_d;
      werr_q   <= werr_d;
      err_q    <= err_d;
      tot_q    <= tot_d;
      relock_q <= relock_d;
      led_q    <= led_d;
    end
  end

  assign o_err    = err_q;
  assign o_tot    = tot_q;
  assign o_relock = relock_q;
  assign o_locked = (st_q == ST_LOCKED);
  assign o_led    = led_q;

endmodule

// File: rtl/ber_multich_checker.sv
// N-lane PRBS BER checker: one independent ber_chk_lane per received bit,
// sharing the receive-enable/symbol strobe and counter clear.
module ber_multich_checker
  import ber_pkg::*;
#(
  parameter int                  NCH          = 2,
  parameter int                  PRBS_LEN     = 9,
  parameter logic [PRBS_LEN-1:0] PRBS_TAPS    = 9'h110,
  parameter int                  SYNC_WIN     = 511,
  parameter int                  LOCK_ERR_MAX = 0,
  parameter int                  LOSS_WIN     = 1024,
  parameter int                  LOSS_ERR_MAX = 64,
  parameter int                  CNT_W        = 64
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_en_rx,
  input  logic                 i_en_rate1,
  input  logic [NCH-1:0]       i_rx_bit,
  input  logic                 i_clear_cnt,
  output logic [NCH*CNT_W-1:0] o_accum_err,
  output logic [NCH*CNT_W-1:0] o_accum_tot,
  output logic [NCH*8-1:0]     o_relock_cnt,
  output logic [NCH-1:0]       o_locked,
  output logic [NCH-1:0]       o_ber_ok_led
);

  logic stb;
  assign stb = i_en_rx & i_en_rate1;

  for (genvar n = 0; n < NCH; n++) begin : g_lane
    ber_chk_lane #(
      .PRBS_LEN    (PRBS_LEN),
      .PRBS_TAPS   (PRBS_TAPS),
      .SYNC_WIN    (SYNC_WIN),
      .LOCK_ERR_MAX(LOCK_ERR_MAX),
      .LOSS_WIN    (LOSS_WIN),
      .LOSS_ERR_MAX(LOSS_ERR_MAX),
      .CNT_W       (CNT_W)
    ) u_lane (
      .clk     (clk),
      .i_reset (i_reset),
      .i_stb   (stb),
      .i_clear (i_clear_cnt),
      .i_rx    (i_rx_bit[n]),
      .o_err   (o_accum_err[n*CNT_W +: CNT_W]),
      .o_tot   (o_accum_tot[n*CNT_W +: CNT_W]),
      .o_relock(o_relock_cnt[n*8 +: 8]),
      .o_locked(o_locked[n]),
      .o_led   (o_ber_ok_led[n])
    );
  end

endmodule

// File: tb/tb_ber_multich_checker.sv
// Randomised bench for ber_multich_checker: PRBS9 streams with random strobe
// gaps, checked against a bit-history reference model and fixed expectations.
module tb_ber_multich_checker;
  localparam int NCH = 2, CW = 64, CW4 = 4;
  localparam int MD_LOAD = 0, MD_QUAL = 1, MD_LOCKED = 2;
  localparam int SRC_PRBS = 0, SRC_RAND = 1, SRC_ZERO = 2;

  logic clk = 1'b0, rst = 1'b0, en_rx = 1'b0, en_r1 = 1'b0, clr = 1'b0;
  logic [NCH-1:0] rx = '0;
  logic [NCH*CW-1:0] acc_err, acc_tot;
  logic [NCH*8-1:0] relock, relock4;
  logic [NCH-1:0] locked, led, locked4, led4;
  logic [NCH*CW4-1:0] err4, tot4;

  ber_multich_checker #(.NCH(NCH), .CNT_W(CW)) dut (
    .clk(clk), .i_reset(rst), .i_en_rx(en_rx), .i_en_rate1(en_r1), .i_rx_bit(rx),
    .i_clear_cnt(clr), .o_accum_err(acc_err), .o_accum_tot(acc_tot),
    .o_relock_cnt(relock), .o_locked(locked), .o_ber_ok_led(led));

  ber_multich_checker #(.NCH(NCH), .CNT_W(CW4)) dut4 (
    .clk(clk), .i_reset(rst), .i_en_rx(en_rx), .i_en_rate1(en_r1), .i_rx_bit(rx),
    .i_clear_cnt(clr), .o_accum_err(err4), .o_accum_tot(tot4),
    .o_relock_cnt(relock4), .o_locked(locked4), .o_ber_ok_led(led4));

  always #5 clk = ~clk;

  int vecs = 0, fails = 0;
  logic [8:0] gen [NCH];

  // Reference model: bit history queue (oldest first), prediction s[n-9]^s[n-5].
  int m_mode[NCH], m_cnt[NCH], m_qerr[NCH], m_wcnt[NCH], m_werr[NCH], m_relock[NCH];
  longint unsigned m_err[NCH], m_tot[NCH];
  bit m_led[NCH];
  bit m_hist[NCH][$];

  function automatic longint unsigned err_of(input int l); return acc_err[l*CW +: CW]; endfunction
  function automatic longint unsigned tot_of(input int l); return acc_tot[l*CW +: CW]; endfunction
  function automatic int relock_of(input int l); return int'(relock[l*8 +: 8]); endfunction
  function automatic int tot4_of(input int l); return int'(tot4[l*CW4 +: CW4]); endfunction

  task automatic model_reset();
    for (int l = 0; l < NCH; l++) begin
      m_mode[l] = MD_LOAD; m_cnt[l] = 0; m_qerr[l] = 0; m_wcnt[l] = 0; m_werr[l] = 0;
      m_relock[l] = 0; m_err[l] = 0; m_tot[l] = 0; m_led[l] = 0;
      m_hist[l].delete();
      repeat (9) m_hist[l].push_back(1'b0);
    end
  endtask

  task automatic model_step(input bit stb, input bit c, input logic [NCH-1:0] b);
    for (int l = 0; l < NCH; l++) begin
      if (stb) begin
        bit p, e;
        int ones;
        p = m_hist[l][0] ^ m_hist[l][4];
        e = b[l] ^ p;
        void'(m_hist[l].pop_front());
        if (m_mode[l] == MD_LOAD) begin
          m_hist[l].push_back(b[l]);
          m_cnt[l]++;
          if (m_cnt[l] == 9) begin
            m_cnt[l] = 0;
            ones = 0;
            foreach (m_hist[l][k]) ones += int'(m_hist[l][k]);
            if (ones != 0) begin m_mode[l] = MD_QUAL; m_qerr[l] = 0; end
          end
        end else if (m_mode[l] == MD_QUAL) begin
          m_hist[l].push_back(p);
          m_qerr[l] += int'(e);
          m_cnt[l]++;
          if (m_cnt[l] == 511) begin
            m_cnt[l] = 0;
            m_mode[l] = (m_qerr[l] == 0) ? MD_LOCKED : MD_LOAD;
            m_wcnt[l] = 0; m_werr[l] = 0;
          end
        end else begin
          m_hist[l].push_back(p);
          m_tot[l]++;
          m_err[l] += longint'(e);
          m_wcnt[l]++;
          m_werr[l] += int'(e);
          if (m_wcnt[l] == 1024) begin
            m_led[l] = (m_werr[l] == 0);
            if (m_werr[l] > 64) begin m_mode[l] = MD_LOAD; m_led[l] = 0; m_relock[l]++; end
            m_wcnt[l] = 0; m_werr[l] = 0;
          end
        end
      end
      if (c) begin m_err[l] = 0; m_tot[l] = 0; m_relock[l] = 0; end
    end
  endtask

  task automatic cyc(input bit stb, input bit c, input logic [NCH-1:0] b);
    if (stb) begin
      en_rx = 1'b1; en_r1 = 1'b1;
    end else begin
      int r = $urandom_range(0, 2);
      en_rx = (r == 1); en_r1 = (r == 2);
    end
    clr = c; rx = b;
    @(posedge clk);
    if (rst) model_reset(); else model_step(stb, c, b);
    #1;
  endtask

  task automatic strobe1(input int s0, input int s1, input bit inv, input bit c);
    logic [NCH-1:0] b;
    int src[NCH];
    src[0] = s0; src[1] = s1;
    if ($urandom_range(0, 7) == 0) cyc(1'b0, 1'b0, NCH'($urandom));
    for (int l = 0; l < NCH; l++) begin
      case (src[l])
        SRC_PRBS: begin b[l] = gen[l][8] ^ gen[l][4]; gen[l] = {gen[l][7:0], b[l]}; end
        SRC_RAND: b[l] = 1'($urandom);
        default:  b[l] = 1'b0;
      endcase
      if (inv) b[l] = ~b[l];
    end
    cyc(1'b1, c, b);
  endtask

  task automatic run(input int n, input int s0, input int s1, input bit inj);
    for (int i = 0; i < n; i++) strobe1(s0, s1, inj && ((i + 1) % 100 == 0), 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cyc(1'b1, 1'b0, NCH'($urandom));
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3);
    vecs++; if (locked !== '0) begin fails++; $display("FAIL reset_locked: got %b want 0", locked); end
    vecs++; if (led !== '0) begin fails++; $display("FAIL reset_led: got %b want 0", led); end
    vecs++; if (acc_err !== '0) begin fails++; $display("FAIL reset_err: got %h want 0", acc_err); end
    vecs++; if (acc_tot !== '0) begin fails++; $display("FAIL reset_tot: got %h want 0", acc_tot); end
    vecs++; if (relock !== '0) begin fails++; $display("FAIL reset_relock: got %h want 0", relock); end
    vecs++; if (tot4 !== '0 || locked4 !== '0) begin fails++; $display("FAIL reset_dut4: tot %h locked %b want 0", tot4, locked4); end
  endtask

  task automatic test_clean_lock();
    run(519, SRC_PRBS, SRC_PRBS, 1'b0);
    vecs++; if (locked !== 2'b00) begin fails++; $display("FAIL lock_early: got %b want 00 after 519 strobes", locked); end
    run(1, SRC_PRBS, SRC_PRBS, 1'b0);
    vecs++; if (locked !== 2'b11) begin fails++; $display("FAIL lock_520: got %b want 11", locked); end
    run(10000, SRC_PRBS, SRC_PRBS, 1'b0);
    for (int l = 0; l < NCH; l++) begin
      vecs++; if (err_of(l) !== 0) begin fails++; $display("FAIL clean_err[%0d]: got %0d want 0", l, err_of(l)); end
      vecs++; if (tot_of(l) !== 10000) begin fails++; $display("FAIL clean_tot[%0d]: got %0d want 10000", l, tot_of(l)); end
      vecs++; if (tot4_of(l) !== 15) begin fails++; $display("FAIL clean_tot4[%0d]: got %0d want 15", l, tot4_of(l)); end
      vecs++; if (led[l] !== 1'b1) begin fails++; $display("FAIL clean_led[%0d]: got %b want 1", l, led[l]); end
    end
  endtask

  task automatic test_inject();
    cyc(1'b0, 1'b1, '0);
    vecs++; if (acc_tot !== '0 || acc_err !== '0) begin fails++; $display("FAIL clear_idle: tot %h err %h want 0", acc_tot, acc_err); end
    run(10000, SRC_PRBS, SRC_PRBS, 1'b1);
    for (int l = 0; l < NCH; l++) begin
      vecs++; if (err_of(l) !== 100) begin fails++; $display("FAIL inj_err[%0d]: got %0d want 100", l, err_of(l)); end
      vecs++; if (tot_of(l) !== 10000) begin fails++; $display("FAIL inj_tot[%0d]: got %0d want 10000", l, tot_of(l)); end
      vecs++; if (led[l] !== 1'b0) begin fails++; $display("FAIL inj_led[%0d]: got %b want 0", l, led[l]); end
      vecs++; if (locked[l] !== 1'b1) begin fails++; $display("FAIL inj_locked[%0d]: got %b want 1", l, locked[l]); end
    end
  endtask

  task automatic test_loss_relock();
    int fall_i = -1, k = 0;
    cyc(1'b0, 1'b1, '0);
    for (int i = 0; i < 2048; i++) begin
      strobe1(SRC_RAND, SRC_PRBS, 1'b0, 1'b0);
      if (fall_i < 0 && locked[0] === 1'b0) fall_i = i;
      vecs++;
      if (locked[0] !== (m_mode[0] == MD_LOCKED) || led[0] !== m_led[0]) begin
        fails++; $display("FAIL loss_track: strobe %0d locked %b led %b want %b %b", i, locked[0], led[0], m_mode[0] == MD_LOCKED, m_led[0]);
      end
    end
    vecs++; if (fall_i < 0) begin fails++; $display("FAIL loss_fall: lane0 never lost lock in 2048 strobes"); end
    vecs++; if (relock_of(0) !== 1) begin fails++; $display("FAIL loss_relock0: got %0d want 1", relock_of(0)); end
    vecs++; if (relock_of(1) !== 0 || locked[1] !== 1'b1 || err_of(1) !== 0) begin
      fails++; $display("FAIL loss_lane1: relock %0d locked %b err %0d want 0 1 0", relock_of(1), locked[1], err_of(1)); end
    while (!(m_mode[0] == MD_LOAD && m_cnt[0] == 0) && k < 4000) begin
      strobe1(SRC_RAND, SRC_PRBS, 1'b0, 1'b0); k++;
    end
    vecs++; if (k >= 4000) begin fails++; $display("FAIL loss_load_wait: lane0 did not return to LOAD in %0d strobes", k); end
    run(519, SRC_PRBS, SRC_PRBS, 1'b0);
    vecs++; if (locked[0] !== 1'b0) begin fails++; $display("FAIL relock_early: got %b want 0", locked[0]); end
    run(1, SRC_PRBS, SRC_PRBS, 1'b0);
    vecs++; if (locked !== 2'b11) begin fails++; $display("FAIL relock_520: got %b want 11", locked); end
    vecs++; if (relock_of(0) !== m_relock[0]) begin fails++; $display("FAIL relock_cnt: got %0d want %0d", relock_of(0), m_relock[0]); end
  endtask

  task automatic test_stuck_zero();
    do_reset(2);
    for (int i = 0; i < 5000; i++) begin
      strobe1(SRC_ZERO, SRC_ZERO, 1'b0, 1'b0);
      vecs++;
      if (locked !== '0 || acc_tot !== '0) begin
        fails++; $display("FAIL stuck0: strobe %0d locked %b tot %h want 0 0", i, locked, acc_tot);
      end
    end
  endtask

  task automatic test_clear_with_strobe();
    do_reset(2);
    run(557, SRC_PRBS, SRC_PRBS, 1'b0);
    strobe1(SRC_PRBS, SRC_PRBS, 1'b0, 1'b1);
    for (int l = 0; l < NCH; l++) begin
      vecs++; if (err_of(l) !== 0 || tot_of(l) !== 0 || relock_of(l) !== 0) begin
        fails++; $display("FAIL clr_stb[%0d]: err %0d tot %0d relock %0d want 0", l, err_of(l), tot_of(l), relock_of(l)); end
    end
    vecs++; if (locked !== 2'b11) begin fails++; $display("FAIL clr_locked: got %b want 11", locked); end
    strobe1(SRC_PRBS, SRC_PRBS, 1'b0, 1'b0);
    for (int l = 0; l < NCH; l++) begin
      vecs++; if (tot_of(l) !== 1) begin fails++; $display("FAIL clr_next_tot[%0d]: got %0d want 1", l, tot_of(l)); end
    end
  endtask

  task automatic test_saturation_reset();
    do_reset(2);
    run(540, SRC_PRBS, SRC_PRBS, 1'b0);
    for (int l = 0; l < NCH; l++) begin
      vecs++; if (tot4_of(l) !== 15) begin fails++; $display("FAIL sat_tot4[%0d]: got %0d want 15", l, tot4_of(l)); end
      vecs++; if (tot_of(l) !== 20) begin fails++; $display("FAIL sat_tot[%0d]: got %0d want 20", l, tot_of(l)); end
    end
    do_reset(1);
    vecs++; if (locked !== '0 || acc_tot !== '0 || tot4 !== '0 || led !== '0) begin
      fails++; $display("FAIL rst_locked: locked %b tot %h tot4 %h led %b want 0", locked, acc_tot, tot4, led); end
    run(300, SRC_PRBS, SRC_PRBS, 1'b0);
    rst = 1'b1;
    strobe1(SRC_PRBS, SRC_PRBS, 1'b0, 1'b0);
    rst = 1'b0;
    vecs++; if (locked !== '0 || acc_err !== '0 || relock !== '0) begin
      fails++; $display("FAIL rst_qual: locked %b err %h relock %h want 0", locked, acc_err, relock); end
    run(519, SRC_PRBS, SRC_PRBS, 1'b0);
    vecs++; if (locked !== 2'b00) begin fails++; $display("FAIL rst_relock_early: got %b want 00", locked); end
    run(1, SRC_PRBS, SRC_PRBS, 1'b0);
    vecs++; if (locked !== 2'b11 || locked4 !== 2'b11) begin fails++; $display("FAIL rst_relock_520: got %b/%b want 11", locked, locked4); end
  endtask

  initial begin
    gen[0] = 9'h1AA;
    gen[1] = 9'h1FE;
    model_reset();
    test_reset();
    test_clean_lock();
    test_inject();
    test_loss_relock();
    test_stuck_zero();
    test_clear_with_strobe();
    test_saturation_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule

// File: doc/ber_multich_checker.md
# ber_multich_checker

Parametrised, N-channel successor to the two-lane (I/Q) BER checker that feeds the uBlaze. Each lane self-synchronises its local PRBS from the received bit stream, confirms lock over a qualification window, and accumulates error and total-bit counts. While locked, each lane watches for loss of lock and re-acquires automatically. The block sits after the slicer in the receiver and exports its counters to the uBlaze register map.

## Interface
Parameters:
- `NCH`, 2, number of independent lanes.
- `PRBS_LEN`, 9, LFSR order.
- `PRBS_TAPS`, 9'h110, feedback tap mask (bit k = state bit k; default x^9+x^5+1).
- `SYNC_WIN`, 511, bits compared during lock qualification.
- `LOCK_ERR_MAX`, 0, maximum errors in `SYNC_WIN` that still grants lock.
- `LOSS_WIN`, 1024, monitoring window length while locked.
- `LOSS_ERR_MAX`, 64; more than this many errors in one `LOSS_WIN` window declares loss of lock.
- `CNT_W`, 64, width of the accumulators.

Ports:
- `clk`, in, 1, single clock.
- `i_reset`, in, 1, synchronous, active-high.
- `i_en_rx`, in, 1, global receive enable.
- `i_en_rate1`, in, 1, symbol-rate strobe.
- `i_rx_bit`, in, NCH, received bit per lane (bit n = lane n).
- `i_clear_cnt`, in, 1, clears accumulators and relock counters on all lanes.
- `o_accum_err`, out, NCH*CNT_W, error count; lane n occupies `[n*CNT_W +: CNT_W]`.
- `o_accum_tot`, out, NCH*CNT_W, bits compared while locked.
- `o_relock_cnt`, out, NCH*8, number of loss-of-lock events per lane.
- `o_locked`, out, NCH, lane is in LOCKED.
- `o_ber_ok_led`, out, NCH, locked and zero errors in the last completed `LOSS_WIN` window.

## Operation
- Strobe: `stb = i_en_rx & i_en_rate1`. No lane state changes without `stb`, except for reset and clear.
- Predicted bit: `p = ^(lfsr & PRBS_TAPS)`. Error: `e = rx ^ p`.
- Lane FSM:
  - **LOAD**: on each `stb`, `lfsr <= {lfsr[LEN-2:0], rx}`. After `PRBS_LEN` strobes:
    - If `lfsr` is all zero, including the bit being shifted in, restart LOAD. This prevents false lock on a stuck-at-0 input.
    - Otherwise go to QUAL.
  - **QUAL**: on each `stb`, `lfsr <= {lfsr[LEN-2:0], p}` (free-running), and `e` is counted in `qual_err`. After `SYNC_WIN` strobes:
    - `qual_err <= LOCK_ERR_MAX` → go to LOCKED.
    - Otherwise → go to LOAD.
  - **LOCKED**: free-running LFSR. On each `stb`, `tot += 1` and `err += e`. Window counters track errors per `LOSS_WIN` bits.
    - At a window end with `win_err > LOSS_ERR_MAX`: go to LOAD and increment `relock_cnt`. The bit that completes the window is still counted.
- Accumulators and `relock_cnt` saturate at all-ones and never wrap. Only LOCKED updates `err`/`tot`.
- `i_clear_cnt` zeroes `err`, `tot` and `relock_cnt`. It does not affect FSM, LFSR or window state. If it coincides with `stb`, clear wins and that bit is not accumulated.
- `o_ber_ok_led` updates at each window end. It drops immediately on leaving LOCKED.

## Timing
- Reset, and the state after reset:
  - All outputs are 0.
  - FSM is in LOAD with the LOAD counter at 0, `lfsr = 0`, and window counters at 0.
  - `i_reset` overrides all other inputs, including mid-window and mid-QUAL.
- All outputs are registered. A `stb` at cycle t is reflected on the outputs at t+1.
- From reset to lock with a clean stream: `PRBS_LEN + SYNC_WIN` strobes. `o_locked` rises the cycle after the final QUAL strobe.
- Loss of lock: `o_locked` falls the cycle after the window-ending strobe. Re-lock then takes `PRBS_LEN + SYNC_WIN` further strobes.
- The block tolerates arbitrary gaps between strobes. Back-to-back strobes (every cycle) are supported.

## Structure
- The shared package `ber_pkg` holds:
  - The FSM state encoding (LOAD, QUAL, LOCKED).
  - A function computing the PRBS feedback from a state and tap mask.
  - The saturating-increment function.
- The natural sub-module is `ber_chk_lane`: one lane's FSM, LFSR, window logic and counters. The top level is a generate loop over `NCH` plus output packing.

## Test plan
- **Clean lock:** NCH=2; lane 0 is PRBS9 seed 0x1AA, lane 1 seed 0x1FE. Both lanes show `o_locked`=1 after 520 strobes. After 10000 further strobes, err=0 and tot=10000.
- **Injected errors:** invert every 100th bit while locked. After 10000 locked bits, err=100, tot=10000, and `o_ber_ok_led`=0.
- **Loss and relock:** replace the lane-0 stream with random bits for 2048 strobes. `o_locked[0]` falls at the first window end and `o_relock_cnt[0]`=1. Restoring PRBS re-locks within 520 strobes, and lane 1 is unaffected.
- **Stuck-at-0:** hold `i_rx_bit`=0 for 5000 strobes. `o_locked` stays 0 and tot stays 0.
- **Clear with strobe:** assert `i_clear_cnt` in the same cycle as `stb` while locked. The next cycle shows err=tot=relock=0 and `o_locked` stays 1. The following strobe gives tot=1.
- **Saturation and reset:** CNT_W=4, 20 locked strobes → tot=15. Asserting `i_reset` mid-QUAL zeroes all outputs, and lock takes the full 520 strobes again.
